// File: rtl/tile_raster_writer.sv
// Reassembles 3x12 filtered tiles into raster-order 12-pixel row segments
// through a ping-pong band buffer (one bank filling while the other drains).
module tile_raster_writer #(
   parameter int TILES_PER_ROW   = 53,
   parameter int BANDS_PER_FRAME = 160,
   parameter int PIX_W           = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [36*PIX_W-1:0]   in_tile,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [12*PIX_W-1:0]   out_data,
   output logic                  out_sol,
   output logic                  out_eol,
   output logic                  out_eof
);

   localparam int SEG_W = 12*PIX_W;
   localparam int SEGS  = 3*TILES_PER_ROW;
   localparam int AW    = $clog2(SEGS);
   localparam int TW    = $clog2(TILES_PER_ROW);
   localparam int BW    = $clog2(BANDS_PER_FRAME);
   localparam logic [TW-1:0] LAST_T = TW'(TILES_PER_ROW-1);
   localparam logic [AW-1:0] LAST_A = AW'(SEGS-1);
   localparam logic [BW-1:0] LAST_B = BW'(BANDS_PER_FRAME-1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

   logic [SEG_W-1:0] r_bank [2][SEGS];
   logic             r_wb;
   logic             r_rb;
   logic [1:0]       r_full;
   logic [TW-1:0]    r_wt;
   logic [AW-1:0]    r_ra;
   logic [TW-1:0]    r_col;
   logic [1:0]       r_row;
   logic [BW-1:0]    r_band;
   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;
   logic             w_load;
   logic             w_advance;
   logic             w_release;
   logic [AW-1:0]    w_wa0;
   logic [AW-1:0]    w_wa1;
   logic [AW-1:0]    w_wa2;

   assign in_ready = !r_full[r_wb];
   assign w_accept = in_valid && in_ready;
   assign w_wa0    = AW'(r_wt);
   assign w_wa1    = w_wa0 + AW'(TILES_PER_ROW);
   assign w_wa2    = w_wa0 + AW'(2*TILES_PER_ROW);

   // Bank contents are never reset; a discarded partial band is simply overwritten.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_bank[r_wb][w_wa0] <= in_tile[3*SEG_W-1 -: SEG_W];
         r_bank[r_wb][w_wa1] <= in_tile[2*SEG_W-1 -: SEG_W];
         r_bank[r_wb][w_wa2] <= in_tile[SEG_W-1   -: SEG_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb   <= 1'b0;
         r_wt   <= '0;
         r_full <= '0;
      end else begin
         if (w_accept) begin
            if (r_wt == LAST_T) begin
               r_wt          <= '0;
               r_wb          <= ~r_wb;
               r_full[r_wb]  <= 1'b1;
            end else begin
               r_wt <= r_wt + TW'(1);
            end
         end
         // Setting and releasing never target the same bank in one cycle.
         if (w_release) r_full[r_rb] <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_advance   = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: if (r_full[r_rb]) w_state_nxt = S_LOAD;
         S_LOAD: begin
            w_load      = 1'b1;
            w_state_nxt = S_SEND;
         end
         S_SEND: if (out_ready) begin
            if (r_ra == LAST_A) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_advance   = 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Column/row counters shadow r_ra so the flags need no modulo.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rb      <= 1'b0;
         r_ra      <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_band    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sol   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         if (w_load) begin
            out_valid <= 1'b1;
            out_data  <= r_bank[r_rb][r_ra];
            out_sol   <= (r_col == '0);
            out_eol   <= (r_col == LAST_T);
            out_eof   <= (r_col == LAST_T) && (r_row == 2'd2) && (r_band == LAST_B);
         end
         if (w_advance) begin
            out_valid <= 1'b0;
            r_ra      <= r_ra + AW'(1);
            if (r_col == LAST_T) begin
               r_col <= '0;
               r_row <= r_row + 2'd1;
            end else begin
               r_col <= r_col + TW'(1);
            end
         end
         if (w_release) begin
            out_valid <= 1'b0;
            r_ra      <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_rb      <= ~r_rb;
            r_band    <= (r_band == LAST_B) ? '0 : r_band + BW'(1);
         end
      end
   end

endmodule

// File: tb/tb_tile_raster_writer.sv
// Scoreboard bench for tile_raster_writer: expected raster segments are queued
// as each band completes on the input side and checked as segments are accepted.
module tb_tile_raster_writer;

   localparam int TPR    = 53;
   localparam int BPF    = 160;
   localparam int PIX_W  = 8;
   localparam int SEG_W  = 12*PIX_W;
   localparam int TILE_W = 36*PIX_W;
   localparam int SEGS   = 3*TPR;

   typedef struct packed {
      logic [SEG_W-1:0] data;
      logic             sol;
      logic             eol;
      logic             eof;
   } seg_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [TILE_W-1:0] in_tile = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [SEG_W-1:0]  out_data;
   logic              out_sol;
   logic              out_eol;
   logic              out_eof;

   seg_t              exp_q[$];
   logic [SEG_W-1:0]  band_buf [SEGS];
   int                m_wt = 0;
   int                m_band = 0;
   int                compared = 0;
   int                mismatched = 0;
   int                seg_cnt = 0;
   int                eof_cnt = 0;
   bit                have_hold = 0;
   logic [SEG_W+3:0]  held;
   bit                bp_mode = 0;
   int                bp_idx = 0;
   bit [3:0]          bp_pat = 4'b1001;

   always #5 clk = ~clk;

   tile_raster_writer #(
      .TILES_PER_ROW  (TPR),
      .BANDS_PER_FRAME(BPF),
      .PIX_W          (PIX_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_tile  (in_tile),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_sol  (out_sol),
      .out_eol  (out_eol),
      .out_eof  (out_eof)
   );

   // Output monitor: pops on handshakes, checks stability across stalls.
   always @(negedge clk) begin
      seg_t e;
      if (!rst) begin
         if (have_hold) begin
            compared++;
            if ({out_valid, out_data, out_sol, out_eol, out_eof} !== held) begin
               mismatched++;
               $display("FAIL stall_stable: got %h required %h",
                        {out_valid, out_data, out_sol, out_eol, out_eof}, held);
            end
         end
         if (out_valid && out_ready) begin
            seg_cnt++;
            if (out_eof) eof_cnt++;
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_segment: got %h with nothing expected", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sol, out_eol, out_eof} !== e) begin
                  mismatched++;
                  $display("FAIL segment %0d: got %h sol%0b eol%0b eof%0b required %h sol%0b eol%0b eof%0b",
                           seg_cnt, out_data, out_sol, out_eol, out_eof, e.data, e.sol, e.eol, e.eof);
               end
            end
            have_hold = 0;
         end else if (out_valid) begin
            held = {out_valid, out_data, out_sol, out_eol, out_eof};
            have_hold = 1;
         end else begin
            have_hold = 0;
         end
      end
   end

   always @(posedge clk) begin
      if (bp_mode) begin
         #1;
         out_ready = bp_pat[3 - (bp_idx % 4)];
         bp_idx++;
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [TILE_W-1:0] pattern_tile(input int t);
      logic [TILE_W-1:0] v;
      v = '0;
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < 12; p++)
            v[(3-r)*SEG_W - 1 - 8*p -: 8] = 8'(t + r + 16*p);
      return v;
   endfunction

   function automatic logic [TILE_W-1:0] rand_tile();
      logic [TILE_W-1:0] v;
      for (int w = 0; w < TILE_W/32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic void model_accept(input logic [TILE_W-1:0] tile);
      seg_t s;
      for (int r = 0; r < 3; r++) band_buf[r*TPR + m_wt] = tile[(3-r)*SEG_W-1 -: SEG_W];
      m_wt++;
      if (m_wt == TPR) begin
         m_wt = 0;
         for (int a = 0; a < SEGS; a++) begin
            s.data = band_buf[a];
            s.sol  = (a % TPR) == 0;
            s.eol  = (a % TPR) == TPR-1;
            s.eof  = s.eol && (a / TPR) == 2 && m_band == BPF-1;
            exp_q.push_back(s);
         end
         m_band = (m_band == BPF-1) ? 0 : m_band + 1;
      end
   endfunction

   function automatic void flush_model();
      exp_q.delete();
      m_wt = 0;
      m_band = 0;
      have_hold = 0;
   endfunction

   // Entered and left at posedge+1; returns just after the accepting edge.
   task automatic send_tile(input logic [TILE_W-1:0] tile, input int gap);
      int n;
      bit acc;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_tile  = tile;
      n = 0;
      acc = 0;
      while (!acc && n < 2000) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_tile  = rand_tile();
      if (acc) model_accept(tile);
      else begin
         compared++;
         mismatched++;
         $display("FAIL tile_accept_timeout: in_ready stayed 0 for %0d cycles", n);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      compared++;
      if (exp_q.size() != 0 || out_valid) begin
         mismatched++;
         $display("FAIL drain_timeout: %0d segments outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst       = 1'b1;
      flush_model();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if ({out_valid, out_data, out_sol, out_eol, out_eof} !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got %h required 0", {out_valid, out_data, out_sol, out_eol, out_eof});
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      compared++;
      if ({in_ready, out_valid} !== 2'b10) begin
         mismatched++;
         $display("FAIL reset_release: in_ready/out_valid got %b required 10", {in_ready, out_valid});
      end
   endtask

   task automatic test_single_band();
      int start;
      start = seg_cnt;
      out_ready = 1'b1;
      for (int t = 0; t < TPR; t++) send_tile(pattern_tile(t), 0);
      wait_drain(1000);
      compared++;
      if (seg_cnt - start != SEGS) begin
         mismatched++;
         $display("FAIL single_band_count: got %0d required %0d", seg_cnt - start, SEGS);
      end
   endtask

   task automatic test_latency();
      out_ready = 1'b0;
      for (int t = 0; t < TPR; t++) send_tile(rand_tile(), 0);
      @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL latency_n1: out_valid got %b required 0", out_valid);
      end
      @(posedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL latency_n2: out_valid got %b required 1", out_valid);
      end
      out_ready = 1'b1;
      wait_drain(1000);
   endtask

   task automatic test_backpressure();
      int start;
      start = seg_cnt;
      bp_idx  = 0;
      bp_mode = 1;
      for (int t = 0; t < TPR; t++) send_tile(rand_tile(), $urandom_range(0, 1));
      wait_drain(3000);
      bp_mode = 0;
      @(posedge clk);
      #2 out_ready = 1'b0;
      compared++;
      if (seg_cnt - start != SEGS) begin
         mismatched++;
         $display("FAIL backpressure_count: got %0d required %0d", seg_cnt - start, SEGS);
      end
   endtask

   task automatic test_exhaustion();
      int n;
      int start;
      bit seen_hi;
      out_ready = 1'b0;
      for (int t = 0; t < 2*TPR; t++) send_tile(rand_tile(), 0);
      compared++;
      if (in_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL exhaust_drop: in_ready got %b required 0", in_ready);
      end
      seen_hi = 0;
      repeat (20) begin @(posedge clk); #1; if (in_ready !== 1'b0) seen_hi = 1; end
      compared++;
      if (seen_hi) begin
         mismatched++;
         $display("FAIL exhaust_hold: in_ready got 1 while both banks full, required 0");
      end
      start = seg_cnt;
      out_ready = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
      compared++;
      if (in_ready !== 1'b1 || seg_cnt - start != SEGS) begin
         mismatched++;
         $display("FAIL exhaust_release: in_ready %b after %0d segments, required 1 after %0d",
                  in_ready, seg_cnt - start, SEGS);
      end
      for (int t = 0; t < TPR; t++) send_tile(rand_tile(), 0);
      wait_drain(3000);
      compared++;
      if (seg_cnt - start != 3*SEGS) begin
         mismatched++;
         $display("FAIL exhaust_total: got %0d required %0d", seg_cnt - start, 3*SEGS);
      end
   endtask

   task automatic test_reset_mid_band();
      int n;
      out_ready = 1'b1;
      for (int t = 0; t < TPR; t++) send_tile(rand_tile(), 0);
      for (int t = 0; t < 20; t++) send_tile(rand_tile(), 0);
      out_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      #2 rst = 1'b1;
      flush_model();
      #1;
      compared++;
      if ({out_valid, out_data, out_sol, out_eol, out_eof} !== '0) begin
         mismatched++;
         $display("FAIL reset_mid_outputs: got %h required 0", {out_valid, out_data, out_sol, out_eol, out_eof});
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < TPR; t++) send_tile(pattern_tile(t + 100), 0);
      wait_drain(1000);
   endtask

   task automatic test_full_frame();
      int s0;
      int e0;
      do_reset();
      out_ready = 1'b1;
      s0 = seg_cnt;
      e0 = eof_cnt;
      for (int t = 0; t < BPF*TPR; t++) send_tile(rand_tile(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      wait_drain(2000);
      compared++;
      if (seg_cnt - s0 != BPF*SEGS) begin
         mismatched++;
         $display("FAIL frame_count: got %0d required %0d", seg_cnt - s0, BPF*SEGS);
      end
      compared++;
      if (eof_cnt - e0 != 1) begin
         mismatched++;
         $display("FAIL frame_eof_count: got %0d required 1", eof_cnt - e0);
      end
      for (int t = 0; t < TPR; t++) send_tile(rand_tile(), 0);
      wait_drain(1000);
      compared++;
      if (eof_cnt - e0 != 1) begin
         mismatched++;
         $display("FAIL next_frame_eof: got %0d eof pulses required 1", eof_cnt - e0);
      end
   endtask

   initial begin
      test_reset();
      test_single_band();
      test_latency();
      test_backpressure();
      do_reset();
      test_exhaustion();
      test_reset_mid_band();
      test_full_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
